// File: rtl/uart_frame_scheduler.sv
// uart_frame_scheduler: snapshots game state on frame_tick, packs it into
// five tagged 16-bit words and feeds them byte-wise (high byte first) to a
// UART transmitter over a tx_start/tx_done handshake, with inter-byte gap,
// per-byte timeout and frame-drop reporting.
module uart_frame_scheduler #(
    parameter int unsigned GAP_CYC     = 0,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [11:0] pl1_posx,
    input  logic [11:0] pl1_posy,
    input  logic [11:0] ball_posx,
    input  logic [11:0] ball_posy,
    input  logic [3:0]  pl1_score,
    input  logic [3:0]  pl2_score,
    input  logic        flag_point,
    input  logic        end_game,
    input  logic        game_reset,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        busy,
    output logic        frame_sent,
    output logic        frame_dropped,
    output logic        tx_error
);

    localparam int unsigned GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYC);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);

    typedef enum logic [3:0] {
        IDLE, LOAD, SEND_HI, WAIT_HI, GAP_HI, SEND_LO, WAIT_LO, GAP_LO, DONE
    } state_t;

    state_t            state_q, state_d;
    logic [4:0][15:0]  snap_q, snap_d;
    logic [2:0]        idx_q, idx_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [TW-1:0]     to_q, to_d;
    logic [7:0]        tx_data_q, tx_data_d;

    assign tx_data = tx_data_q;

    // State, snapshot, counters and byte register; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            idx_q     <= '0;
            gap_q     <= '0;
            to_q      <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            to_q      <= to_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next-state, counter updates and handshake/status outputs.
    always_comb begin
        state_d       = state_q;
        snap_d        = snap_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        to_d          = to_q;
        tx_data_d     = tx_data_q;
        tx_start      = 1'b0;
        frame_sent    = 1'b0;
        tx_error      = 1'b0;
        busy          = (state_q != IDLE);
        frame_dropped = frame_tick && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    snap_d[0] = {4'h0, 1'b0, game_reset, end_game, flag_point,
                                 pl2_score, pl1_score};
                    snap_d[1] = {4'h3, pl1_posx};
                    snap_d[2] = {4'h4, pl1_posy};
                    snap_d[3] = {4'h5, ball_posx};
                    snap_d[4] = {4'h6, ball_posy};
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                idx_d   = '0;
                state_d = SEND_HI;
            end
            SEND_HI, SEND_LO: begin
                tx_start = 1'b1;
                to_d     = TW'(1);
                state_d  = (state_q == SEND_HI) ? WAIT_HI : WAIT_LO;
            end
            WAIT_HI, WAIT_LO: begin
                // tx_done wins over a simultaneous expiry.
                if (tx_done) begin
                    gap_d = GW'(1);
                    if (GAP_CYC != 0) begin
                        state_d = (state_q == WAIT_HI) ? GAP_HI : GAP_LO;
                    end else if (state_q == WAIT_HI) begin
                        state_d = SEND_LO;
                    end else if (idx_q == 3'd4) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND_HI;
                    end
                end else if (to_q == TO_MAX) begin
                    tx_error = 1'b1;
                    state_d  = IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            GAP_HI, GAP_LO: begin
                if (gap_q != GAP_MAX) begin
                    gap_d = gap_q + GW'(1);
                end else if (state_q == GAP_HI) begin
                    state_d = SEND_LO;
                end else if (idx_q == 3'd4) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = SEND_HI;
                end
            end
            DONE: begin
                frame_sent = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Byte is registered on entry to a SEND state so it is valid with
        // tx_start and held until the next SEND (and through IDLE).
        if (state_d == SEND_HI) begin
            tx_data_d = snap_d[idx_d][15:8];
        end else if (state_d == SEND_LO) begin
            tx_data_d = snap_d[idx_d][7:0];
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler: instance 0 has no inter-byte gap,
// instance 1 inserts 3 gap cycles; both use a 20-cycle TX timeout.
module tb_uart_frame_scheduler;

    logic        clk;
    logic        rst;
    logic        ft0, ft1, td0, td1;
    logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
    logic [3:0]  pl1_score, pl2_score;
    logic        flag_point, end_game, game_reset;

    logic [7:0]  txd0, txd1;
    logic        ts0, ts1, bz0, bz1, fs0, fs1, fd0, fd1, te0, te1;

    logic        sel;
    logic [7:0]  o_txd;
    logic        o_ts, o_bz, o_fs, o_fd, o_te;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] EXP_A [10] = '{8'h01, 8'h53, 8'h31, 8'h23, 8'h40,
                               8'hA5, 8'h57, 8'hFF, 8'h60, 8'h01};
    logic [7:0] EXP_B [10] = '{8'h02, 8'hF0, 8'h3A, 8'hBC, 8'h40,
                               8'h01, 8'h50, 8'h00, 8'h6F, 8'hFF};
    logic [7:0] EXP_C [10] = '{8'h06, 8'h2A, 8'h3A, 8'hBC, 8'h40,
                               8'h01, 8'h50, 8'h00, 8'h6F, 8'hFF};

    uart_frame_scheduler #(.GAP_CYC(0), .TIMEOUT_CYC(20)) dut0 (
        .clk(clk), .rst(rst), .frame_tick(ft0),
        .pl1_posx(pl1_posx), .pl1_posy(pl1_posy),
        .ball_posx(ball_posx), .ball_posy(ball_posy),
        .pl1_score(pl1_score), .pl2_score(pl2_score),
        .flag_point(flag_point), .end_game(end_game), .game_reset(game_reset),
        .tx_data(txd0), .tx_start(ts0), .tx_done(td0), .busy(bz0),
        .frame_sent(fs0), .frame_dropped(fd0), .tx_error(te0)
    );

    uart_frame_scheduler #(.GAP_CYC(3), .TIMEOUT_CYC(20)) dut1 (
        .clk(clk), .rst(rst), .frame_tick(ft1),
        .pl1_posx(pl1_posx), .pl1_posy(pl1_posy),
        .ball_posx(ball_posx), .ball_posy(ball_posy),
        .pl1_score(pl1_score), .pl2_score(pl2_score),
        .flag_point(flag_point), .end_game(end_game), .game_reset(game_reset),
        .tx_data(txd1), .tx_start(ts1), .tx_done(td1), .busy(bz1),
        .frame_sent(fs1), .frame_dropped(fd1), .tx_error(te1)
    );

    assign o_txd = sel ? txd1 : txd0;
    assign o_ts  = sel ? ts1  : ts0;
    assign o_bz  = sel ? bz1  : bz0;
    assign o_fs  = sel ? fs1  : fs0;
    assign o_fd  = sel ? fd1  : fd0;
    assign o_te  = sel ? te1  : te0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_tick(input logic v);
        if (sel) ft1 = v; else ft0 = v;
    endtask

    task automatic set_done(input logic v);
        if (sel) td1 = v; else td0 = v;
    endtask

    task automatic set_inputs(input logic [11:0] px, py, bx, by,
                              input logic [3:0] s1, s2,
                              input logic fp, eg, gr);
        pl1_posx = px; pl1_posy = py; ball_posx = bx; ball_posy = by;
        pl1_score = s1; pl2_score = s2;
        flag_point = fp; end_game = eg; game_reset = gr;
    endtask

    // Called in a tx_start cycle; returns at the negedge after tx_done.
    task automatic do_byte(input logic [7:0] e, input int b);
        chk($sformatf("tx_start b%0d", b), 32'(o_ts), 32'd1);
        chk($sformatf("tx_data b%0d", b), 32'(o_txd), 32'(e));
        repeat (9) begin
            @(negedge clk);
            ft0 = 1'b0; ft1 = 1'b0;
        end
        chk($sformatf("tx_data_hold b%0d", b), 32'(o_txd), 32'(e));
        chk($sformatf("tx_start_low b%0d", b), 32'(o_ts), 32'd0);
        @(negedge clk);
        set_done(1'b1);
        @(negedge clk);
        set_done(1'b0);
    endtask

    task automatic wait_gap(input int gap, input int b);
        repeat (gap) begin
            chk($sformatf("gap_idle b%0d", b), 32'(o_ts), 32'd0);
            @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [7:0] e [10], input int gap,
                             input bit iso, input bit drop);
        set_tick(1'b1);
        @(negedge clk);
        set_tick(1'b0);
        chk("load_busy", 32'(o_bz), 32'd1);
        chk("load_no_start", 32'(o_ts), 32'd0);
        @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            do_byte(e[b], b);
            if (b == 0 && iso) ball_posx = 12'h000;
            wait_gap(gap, b);
            if (b < 9 && drop && b == 4) begin
                set_tick(1'b1);
                #1;
                chk("drop_mid", 32'(o_fd), 32'd1);
            end
        end
        chk("done_sent", 32'(o_fs), 32'd1);
        chk("done_busy", 32'(o_bz), 32'd1);
        if (drop) begin
            set_tick(1'b1);
            #1;
            chk("drop_done", 32'(o_fd), 32'd1);
        end
        @(negedge clk);
        set_tick(1'b0);
        #1;
        chk("after_busy", 32'(o_bz), 32'd0);
        chk("after_sent", 32'(o_fs), 32'd0);
        chk("after_drop", 32'(o_fd), 32'd0);
        repeat (5) @(negedge clk);
        chk("no_extra_frame", 32'(o_ts | o_bz), 32'd0);
    endtask

    initial begin
        rst = 1'b0; sel = 1'b0;
        ft0 = 1'b0; ft1 = 1'b0; td0 = 1'b0; td1 = 1'b0;
        set_inputs(12'h123, 12'h0A5, 12'h7FF, 12'h001, 4'd3, 4'd5, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_tx_start", 32'(ts0), 32'd0);
        chk("rst_busy", 32'(bz0), 32'd0);
        chk("rst_tx_data", 32'(txd0), 32'd0);
        chk("rst_sent", 32'(fs0), 32'd0);
        chk("rst_err", 32'(te0), 32'd0);
        chk("rst_busy1", 32'(bz1), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Nominal frame, snapshot isolation, and drops mid-frame and in DONE.
        sel = 1'b0;
        run_frame(EXP_A, 0, 1'b1, 1'b1);
        chk("idle_holds_data", 32'(txd0), 32'h01);

        // Gap of 3 cycles after every tx_done.
        sel = 1'b1;
        set_inputs(12'hABC, 12'h001, 12'h000, 12'hFFF, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0);
        run_frame(EXP_B, 3, 1'b0, 1'b0);

        // Timeout on the 4th byte, then a clean frame.
        sel = 1'b0;
        set_inputs(12'h123, 12'h0A5, 12'h7FF, 12'h001, 4'd3, 4'd5, 1'b1, 1'b0, 1'b0);
        set_tick(1'b1);
        @(negedge clk);
        set_tick(1'b0);
        @(negedge clk);
        for (int b = 0; b < 3; b++) do_byte(EXP_A[b], b);
        chk("to_start", 32'(o_ts), 32'd1);
        chk("to_data", 32'(o_txd), 32'h23);
        repeat (19) @(negedge clk);
        chk("to_not_yet", 32'(o_te), 32'd0);
        chk("to_busy", 32'(o_bz), 32'd1);
        @(negedge clk);
        chk("to_error", 32'(o_te), 32'd1);
        chk("to_no_sent", 32'(o_fs), 32'd0);
        @(negedge clk);
        chk("to_err_pulse", 32'(o_te), 32'd0);
        chk("to_idle", 32'(o_bz), 32'd0);
        chk("to_no_sent2", 32'(o_fs), 32'd0);
        set_inputs(12'hABC, 12'h001, 12'h000, 12'hFFF, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0);
        run_frame(EXP_B, 0, 1'b0, 1'b0);

        // Asynchronous reset between edges, spurious tx_done, restart.
        set_inputs(12'hABC, 12'h001, 12'h000, 12'hFFF, 4'hA, 4'h2, 1'b0, 1'b1, 1'b1);
        set_tick(1'b1);
        @(negedge clk);
        set_tick(1'b0);
        @(negedge clk);
        chk("ar_start", 32'(o_ts), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_tx_start", 32'(o_ts), 32'd0);
        chk("ar_busy", 32'(o_bz), 32'd0);
        chk("ar_tx_data", 32'(o_txd), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        td0 = 1'b1;
        @(negedge clk);
        td0 = 1'b0;
        chk("ar_spurious_busy", 32'(o_bz), 32'd0);
        repeat (3) @(negedge clk);
        chk("ar_spurious_start", 32'(o_ts), 32'd0);
        run_frame(EXP_C, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_scheduler.md
Name: uart_frame_scheduler

Overview:
Transmit-side sequencer for the board-to-board game-state link on the master board. On each frame tick it snapshots the game state and packs it into five tagged 16-bit words, compatible with the receiving board's tag decoder. It serialises each word as two bytes into the UART transmitter through a start/done handshake. It also provides frame-drop and TX-timeout reporting.

Parameters:
GAP_CYC, 0, idle clock cycles inserted after each tx_done before the next tx_start.
TIMEOUT_CYC, 100000, cycles allowed from tx_start to tx_done before the frame is aborted; must be ≥1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle request to send one frame
pl1_posx  in  12  player 1 x position
pl1_posy  in  12  player 1 y position
ball_posx  in  12  ball x position
ball_posy  in  12  ball y position
pl1_score  in  4  player 1 score
pl2_score  in  4  player 2 score
flag_point  in  1  point-scored flag
end_game  in  1  end-of-game flag
game_reset  in  1  remote reset request
tx_data  out  8  byte to UART transmitter
tx_start  out  1  one-cycle pulse: start sending tx_data
tx_done  in  1  one-cycle pulse from UART: byte finished
busy  out  1  high while a frame is in progress
frame_sent  out  1  one-cycle pulse: all 10 bytes acknowledged
frame_dropped  out  1  one-cycle pulse: frame_tick ignored while busy
tx_error  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE immediately.
  - The snapshot registers, word index, gap counter and timeout counter are cleared.
  - Reset mid-frame aborts the frame; nothing resumes after release.
- Snapshot: frame_tick in IDLE captures all inputs on that edge. Later input changes do not affect the frame in flight. The five words, in transmit order:
  - W0 = {4'h0, 1'b0, game_reset, end_game, flag_point, pl2_score, pl1_score}
  - W1 = {4'h3, pl1_posx}
  - W2 = {4'h4, pl1_posy}
  - W3 = {4'h5, ball_posx}
  - W4 = {4'h6, ball_posy}
- Byte order: each word is sent high byte [15:8] first, then low byte [7:0]. A frame is 10 bytes.
- FSM states:
  - IDLE: frame_tick → LOAD.
  - LOAD: word index=0 → SEND_HI.
  - SEND_HI: tx_start=1 for exactly one cycle with the high byte → WAIT_HI.
  - WAIT_HI: on tx_done → GAP_HI (or straight to SEND_LO when GAP_CYC=0).
  - SEND_LO / WAIT_LO / GAP_LO: same sequence for the low byte.
  - After the low-byte tx_done: if index=4 → DONE; else index+1 → SEND_HI.
  - DONE: frame_sent=1 for one cycle → IDLE.
- Latency and gaps:
  - frame_tick sampled at edge N → tx_start high in the cycle after N+1 (LOAD occupies one cycle).
  - With GAP_CYC=0, the next tx_start is asserted exactly 1 cycle after tx_done.
- tx_data stability: tx_data is driven in the tx_start cycle and held stable until the matching tx_done. It holds its last value in IDLE.
- tx_done rules:
  - Ignored outside WAIT states.
  - Ignored in the same cycle as tx_start.
  - Extra pulses never advance the index twice.
- busy: high from LOAD through DONE inclusive; low in IDLE.
- frame_tick while not IDLE: frame_dropped pulses for that cycle, with no queueing and no effect on the current frame. frame_tick in the DONE cycle is also dropped.
- Timeout:
  - The counter loads on tx_start and counts in WAIT states.
  - If it reaches TIMEOUT_CYC without tx_done, tx_error pulses one cycle and the FSM goes to IDLE without frame_sent.
  - A tx_done arriving in the same cycle as expiry counts as success.
- Counters are sized with $clog2 of their parameter (min width 1) and saturate; they never wrap.

Test Plan:
- Nominal frame: pl1=(0x123,0x0A5), ball=(0x7FF,0x001), scores 3/5, flag_point=1, end_game=0, game_reset=0; UART model returns tx_done 10 cycles after each tx_start → bytes 0x01,0x53,0x31,0x23,0x40,0xA5,0x57,0xFF,0x60,0x01. frame_sent pulses once; busy is low afterwards.
- Snapshot isolation: change ball_posx to 0x000 after the first byte → W3 still sends 0x57,0xFF.
- Drop: frame_tick again mid-frame and in the DONE cycle → frame_dropped pulses on both; exactly one frame of 10 bytes is sent.
- Gap timing: GAP_CYC=3 → tx_start occurs exactly 4 cycles after each tx_done. GAP_CYC=0 → exactly 1 cycle after.
- Timeout: TIMEOUT_CYC=20, suppress tx_done on the 4th byte → tx_error pulses 20 cycles after that tx_start; no frame_sent. A following frame_tick sends a full frame.
- Async reset: assert rst=0 mid-byte between edges → outputs are 0 immediately. After release a spurious tx_done is ignored, and frame_tick restarts from byte 0x0X.
